// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard status from the datapath and stage strobes back to it
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0] ID_Rs, ID_Rt, EX_RegDstData;
  logic ID_UsesRt, EX_MemRead;
  logic MEM_Branch, MEM_Zero, MEM_Jump, MEM_MemRead, MEM_MemWrite, Mem_Ready;
  logic PC_Ld, IFID_Ld, IDEX_Ld, EXMEM_Ld, MEMWB_Ld;
  logic IFID_Clr, IDEX_Clr, EXMEM_Clr, MEMWB_Clr;
  logic Redirect, Mem_Req, Mem_Err;
  logic [CNT_W-1:0] StallCnt, FlushCnt;
  modport master (
    input ID_Rs, ID_Rt, EX_RegDstData, ID_UsesRt, EX_MemRead,
    input MEM_Branch, MEM_Zero, MEM_Jump, MEM_MemRead, MEM_MemWrite, Mem_Ready,
    output PC_Ld, IFID_Ld, IDEX_Ld, EXMEM_Ld, MEMWB_Ld,
    output IFID_Clr, IDEX_Clr, EXMEM_Clr, MEMWB_Clr,
    output Redirect, Mem_Req, Mem_Err, StallCnt, FlushCnt
  );
  modport slave (
    output ID_Rs, ID_Rt, EX_RegDstData, ID_UsesRt, EX_MemRead,
    output MEM_Branch, MEM_Zero, MEM_Jump, MEM_MemRead, MEM_MemWrite, Mem_Ready,
    input PC_Ld, IFID_Ld, IDEX_Ld, EXMEM_Ld, MEMWB_Ld,
    input IFID_Clr, IDEX_Clr, EXMEM_Clr, MEMWB_Clr,
    input Redirect, Mem_Req, Mem_Err, StallCnt, FlushCnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stage load/clear sequencing for load-use stalls, redirects and memory waits
module pipeline_hazard_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W = 16
) (
  input logic Clk,
  input logic Clr_n,
  pipeline_hazard_ctrl_if.master bus
);
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  logic [WW-1:0] wait_cnt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic mem_err;
  logic acc, waiting, freeze, timeout, redir, load_use;
  // classify the cycle; a pending memory access outranks redirect, which outranks load-use
  always_comb begin
    acc = bus.MEM_MemRead | bus.MEM_MemWrite;
    waiting = acc & ~bus.Mem_Ready;
    freeze = waiting & (wait_cnt < WAIT_LIM);
    timeout = waiting & (wait_cnt == WAIT_LIM);
    redir = ~freeze & ((bus.MEM_Branch & bus.MEM_Zero) | bus.MEM_Jump);
    load_use = ~freeze & ~redir & bus.EX_MemRead & (bus.EX_RegDstData != 5'd0) &
               ((bus.EX_RegDstData == bus.ID_Rs) | (bus.ID_UsesRt & (bus.EX_RegDstData == bus.ID_Rt)));
  end
  // stage strobes; while reset is low every stage holds a bubble
  always_comb begin
    bus.PC_Ld = Clr_n & ~freeze & ~load_use;
    bus.IFID_Ld = Clr_n & ~freeze & ~load_use;
    bus.IDEX_Ld = Clr_n & ~freeze;
    bus.EXMEM_Ld = Clr_n & ~freeze;
    bus.MEMWB_Ld = Clr_n;
    bus.IFID_Clr = ~Clr_n | redir;
    bus.IDEX_Clr = ~Clr_n | redir | load_use;
    bus.EXMEM_Clr = ~Clr_n | redir;
    bus.MEMWB_Clr = ~Clr_n | freeze;
    bus.Redirect = Clr_n & redir;
    bus.Mem_Req = Clr_n & acc;
    bus.Mem_Err = mem_err;
    bus.StallCnt = stall_cnt;
    bus.FlushCnt = flush_cnt;
  end
  // wait watchdog, sticky timeout flag and saturating performance counters
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      wait_cnt <= '0;
      mem_err <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      wait_cnt <= freeze ? wait_cnt + 1'b1 : '0;
      if (timeout) mem_err <= 1'b1;
      if (!bus.PC_Ld && stall_cnt != CNT_SAT) stall_cnt <= stall_cnt + 1'b1;
      if (redir && flush_cnt != CNT_SAT) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central sequencing controller for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It:
- generates every stage's load and clear strobe;
- handles load-use stalls, branch/jump redirects resolved in MEM, and multi-cycle data-memory waits with a timeout watchdog;
- keeps saturating stall and flush performance counters.

Sits beside the datapath; the pipeline registers consume its `*_Ld` / `*_Clr` outputs, where Clr has priority over Ld inside each register.

## Interface
Parameters:
- `WAIT_MAX`, default 15: maximum consecutive memory-wait cycles before timeout.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `Clk` in 1: single clock; all state updates on the rising edge.
- `Clr_n` in 1: reset, asynchronous, active-low.
- `ID_Rs`, `ID_Rt` in 5 each: source registers of the instruction in ID.
- `ID_UsesRt` in 1: the ID instruction reads Rt.
- `EX_MemRead` in 1: the EX instruction is a load.
- `EX_RegDstData` in 5: destination register of the EX instruction.
- `MEM_Branch`, `MEM_Zero`, `MEM_Jump` in 1 each: branch/jump resolution from the EX/MEM register.
- `MEM_MemRead`, `MEM_MemWrite` in 1 each: the MEM instruction accesses data memory.
- `Mem_Ready` in 1: data memory completes the access this cycle.
- `PC_Ld`, `IFID_Ld`, `IDEX_Ld`, `EXMEM_Ld`, `MEMWB_Ld` out 1 each: stage load enables.
- `IFID_Clr`, `IDEX_Clr`, `EXMEM_Clr`, `MEMWB_Clr` out 1 each: synchronous bubble insertion into the stage.
- `Redirect` out 1: PC mux selects the branch/jump target.
- `Mem_Req` out 1: data-memory request strobe.
- `Mem_Err` out 1: sticky timeout flag.
- `StallCnt`, `FlushCnt` out `CNT_W` each: saturating event counters.

## Operation
Internal signals:
- `acc = MEM_MemRead | MEM_MemWrite`
- `WaitCnt`: register, width ceil(log2(WAIT_MAX+1)), reset 0.

Modes, evaluated combinationally each cycle in priority order (Mealy; outputs are sampled by the registers at the next edge):
1. **Reset** (`Clr_n` = 0):
   - all `*_Ld` = 0, all `*_Clr` = 1, `Redirect` = 0, `Mem_Req` = 0.
   - `Mem_Err`, `StallCnt`, `FlushCnt`, `WaitCnt` = 0.
2. **FREEZE**, when `acc & !Mem_Ready & WaitCnt < WAIT_MAX`:
   - `PC_Ld`, `IFID_Ld`, `IDEX_Ld`, `EXMEM_Ld` = 0.
   - `MEMWB_Ld` = 1 and `MEMWB_Clr` = 1 (bubble into WB).
   - `WaitCnt` increments.
3. **TIMEOUT**, when `acc & !Mem_Ready & WaitCnt == WAIT_MAX`:
   - treated as ready; outputs as RUN.
   - `Mem_Err` sets (sticky until reset); `WaitCnt` clears.
4. **REDIRECT**, when `(MEM_Branch & MEM_Zero) | MEM_Jump`:
   - all Ld = 1, `Redirect` = 1.
   - `IFID_Clr`, `IDEX_Clr`, `EXMEM_Clr` = 1, squashing the 3 younger instructions.
   - `FlushCnt` increments.
5. **LOAD_USE**, when `EX_MemRead & EX_RegDstData != 0 & (EX_RegDstData == ID_Rs | (ID_UsesRt & EX_RegDstData == ID_Rt))`:
   - `PC_Ld` = 0, `IFID_Ld` = 0, `IDEX_Clr` = 1.
   - remaining Ld = 1.
6. **RUN**: all Ld = 1, all Clr = 0, `Redirect` = 0.

Bookkeeping:
- `WaitCnt` clears in every non-FREEZE cycle.
- `Mem_Req = acc & Clr_n` in all modes, including FREEZE, so the request is held stable.
- `StallCnt` increments in every cycle with `Clr_n` = 1 and `PC_Ld` = 0.
- Both performance counters saturate at all-ones and never wrap.

## Timing
- Control outputs are combinational from inputs plus `WaitCnt`; there is no added latency.
- Counters and `Mem_Err` update at the edge closing the qualifying cycle.
- Load-use costs exactly 1 bubble. The next cycle has EX = bubble, so the condition falls without held state.
- Redirect costs 3 squashed slots. The target is fetched in the cycle after `Redirect`.
- FREEZE lasts until the first cycle with `Mem_Ready` = 1. It lasts at most `WAIT_MAX` cycles, and the watchdog releases on cycle `WAIT_MAX`+1.
- Simultaneous events:
  - FREEZE beats REDIRECT and LOAD_USE; both are re-evaluated after release.
  - REDIRECT beats LOAD_USE; the ID instruction is squashed anyway.
- Reset asserted mid-FREEZE: aborts immediately and asynchronously. `WaitCnt` = 0 and no `Mem_Err` is raised.
- Reset deassertion: the first edge with `Clr_n` = 1 behaves as RUN.

## Test plan
- **Load-use:** EX_MemRead=1, EX_RegDstData=5, ID_Rs=5 -> PC_Ld=0, IFID_Ld=0, IDEX_Clr=1 for exactly 1 cycle, StallCnt 0->1. Repeat with EX_RegDstData=0 -> no stall.
- **Branch taken:** MEM_Branch=1, MEM_Zero=1, with a load-use also present -> Redirect=1, IFID/IDEX/EXMEM_Clr=1, PC_Ld=1, FlushCnt=1, StallCnt unchanged. Repeat with MEM_Zero=0 -> RUN.
- **Memory wait:** MEM_MemRead=1, Mem_Ready low for 3 cycles -> 3 FREEZE cycles with MEMWB_Clr=1 and Mem_Req=1 throughout, StallCnt=3. Release on the 4th cycle, Mem_Err=0.
- **Timeout:** Mem_Ready held low, WAIT_MAX=15 -> freeze for 15 cycles, release on cycle 16, Mem_Err=1 and stays 1 through later RUN cycles.
- **Reset mid-freeze:** drop Clr_n during freeze cycle 2 -> outputs go to reset values immediately. After release, RUN with WaitCnt=0 and counters=0.
- **Saturation:** preload by 65,540 stall cycles -> StallCnt=0xFFFF, no wrap.
